// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core: sequences fetch, decode, execute,
// memory and write-back, and drives every datapath strobe and mux select.
module multicycle_ctrl (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [6:0] i_Op,
    input  logic       i_MemReady,
    input  logic       i_Take,
    output logic       o_PCWrite,
    output logic       o_IRWrite,
    output logic       o_AdrSrc,
    output logic       o_MemWrite,
    output logic       o_RegWrite,
    output logic [1:0] o_ResultSrc,
    output logic [1:0] o_ALUSrcA,
    output logic [1:0] o_ALUSrcB,
    output logic [1:0] o_ALUOp,
    output logic [2:0] o_ImmSrc,
    output logic       o_Illegal,
    output logic [3:0] o_State
);

    localparam logic [2:0] RT = 3'd0;
    localparam logic [2:0] IT = 3'd1;
    localparam logic [2:0] ST = 3'd2;
    localparam logic [2:0] BT = 3'd3;
    localparam logic [2:0] JT = 3'd4;
    localparam logic [2:0] UT = 3'd5;
    localparam logic [2:0] NO = 3'd6;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXER   = 4'd6,
        EXEI   = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        JAL    = 4'd10,
        JALR   = 4'd11,
        LINK   = 4'd12,
        LUI    = 4'd13,
        AUIPC  = 4'd14,
        TRAP   = 4'd15
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       mem_write;
        logic       reg_write;
        logic       adr_src;
        logic       illegal;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
    } ctrl_t;

    // State-only (Moore) control word; registered alongside the state itself.
    function automatic ctrl_t moore_of(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH:  begin c.alu_src_b = 2'b10; c.result_src = 2'b10; end
            DECODE: begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
            MEMADR: begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
            MEMRD:  c.adr_src = 1'b1;
            MEMWB:  begin c.result_src = 2'b01; c.reg_write = 1'b1; end
            MEMWR:  begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
            EXER:   begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
            EXEI:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
            ALUWB:  c.reg_write = 1'b1;
            BRANCH: begin c.alu_src_a = 2'b10; c.alu_op = 2'b01; end
            JAL:    begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_write = 1'b1; end
            JALR: begin
                c.alu_src_a  = 2'b10;
                c.alu_src_b  = 2'b01;
                c.result_src = 2'b10;
                c.pc_write   = 1'b1;
            end
            LINK:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; end
            LUI:    begin c.alu_src_b = 2'b01; c.alu_op = 2'b11; end
            AUIPC:  begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
            TRAP:   c.illegal = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic state_t next_of(input state_t s, input logic [6:0] op,
                                       input logic ready);
        state_t n;
        n = s;
        case (s)
            FETCH:  n = ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: n = MEMADR;
                    OP_RTYPE:          n = EXER;
                    OP_IALU:           n = EXEI;
                    OP_BRANCH:         n = BRANCH;
                    OP_JAL:            n = JAL;
                    OP_JALR:           n = JALR;
                    OP_LUI:            n = LUI;
                    OP_AUIPC:          n = AUIPC;
                    OP_SYSTEM:         n = FETCH;
                    default:           n = TRAP;
                endcase
            end
            MEMADR: n = (op == OP_LOAD) ? MEMRD : MEMWR;
            MEMRD:  n = ready ? MEMWB : MEMRD;
            MEMWB:  n = FETCH;
            MEMWR:  n = ready ? FETCH : MEMWR;
            EXER, EXEI, JAL, LUI, AUIPC: n = ALUWB;
            ALUWB:  n = FETCH;
            BRANCH: n = FETCH;
            JALR:   n = LINK;
            LINK:   n = ALUWB;
            TRAP:   n = TRAP;
            default: n = FETCH;
        endcase
        return n;
    endfunction

    state_t state;
    state_t next_state;
    ctrl_t  ctrl_q;
    ctrl_t  ctrl;
    logic   fetch_accept;
    logic   branch_taken;

    always_comb begin
        next_state = next_of(state, i_Op, i_MemReady);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= FETCH;
            ctrl_q <= moore_of(FETCH);
        end else begin
            state  <= next_state;
            ctrl_q <= moore_of(next_state);
        end
    end

    // Reset acts on the outputs in the same cycle it is asserted, not only after the edge.
    assign ctrl         = i_rst ? moore_of(FETCH) : ctrl_q;
    assign fetch_accept = !i_rst && (state == FETCH) && i_MemReady;
    assign branch_taken = !i_rst && (state == BRANCH) && i_Take;

    assign o_PCWrite   = ctrl.pc_write | fetch_accept | branch_taken;
    assign o_IRWrite   = fetch_accept;
    assign o_AdrSrc    = ctrl.adr_src;
    assign o_MemWrite  = ctrl.mem_write;
    assign o_RegWrite  = ctrl.reg_write;
    assign o_ResultSrc = ctrl.result_src;
    assign o_ALUSrcA   = ctrl.alu_src_a;
    assign o_ALUSrcB   = ctrl.alu_src_b;
    assign o_ALUOp     = ctrl.alu_op;
    assign o_Illegal   = ctrl.illegal;
    assign o_State     = i_rst ? 4'd0 : state;

    always_comb begin
        o_ImmSrc = NO;
        case (i_Op)
            OP_RTYPE:                             o_ImmSrc = RT;
            OP_IALU, OP_LOAD, OP_JALR, OP_SYSTEM: o_ImmSrc = IT;
            OP_STORE:                             o_ImmSrc = ST;
            OP_BRANCH:                            o_ImmSrc = BT;
            OP_JAL:                               o_ImmSrc = JT;
            OP_LUI, OP_AUIPC:                     o_ImmSrc = UT;
            default:                              o_ImmSrc = NO;
        endcase
    end

endmodule
